// File: rtl/arbiter_round_robin_hold_pkg.sv
// Shared types and helpers for the round-robin arbiter with grant hold.
package arbiter_round_robin_hold_pkg;

  // Arbiter control states: nothing granted, or a grant is being held.
  typedef enum logic {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } arb_state_e;

  // Number of bits needed to encode an index in [0, n-1]; never less than 1.
  function automatic int clog2_width(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    if (w == 0) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/arbiter_round_robin_hold_select.sv
// Round-robin winner selection: masks off requesters at or below the last
// grant, prefers the lowest remaining requester above it, and otherwise
// wraps around to the lowest requester overall.
module arbiter_round_robin_hold_select #(
  parameter int WORD_WIDTH = 4
) (
  input  logic [WORD_WIDTH-1:0] requests,
  input  logic [WORD_WIDTH-1:0] last_grant,
  output logic [WORD_WIDTH-1:0] pick
);

  logic [WORD_WIDTH-1:0] thermo;     // last_grant and every bit below it
  logic [WORD_WIDTH-1:0] upper;      // requests strictly above last_grant
  logic [WORD_WIDTH-1:0] upper_low;  // lowest set bit of upper
  logic [WORD_WIDTH-1:0] req_low;    // lowest set bit of requests

  // For a one-hot x, x | (x - 1) fills in every bit at or below x.
  assign thermo    = last_grant | (last_grant - WORD_WIDTH'(1));
  assign upper     = requests & ~thermo;

  // x & -x isolates the lowest set bit (two's complement trick).
  assign upper_low = upper & (~upper + WORD_WIDTH'(1));
  assign req_low   = requests & (~requests + WORD_WIDTH'(1));

  // Requesters above the last winner get first claim; wrap only if none exist.
  assign pick = (upper != '0) ? upper_low : req_low;

endmodule

// File: rtl/arbiter_round_robin_hold.sv
// Registered round-robin arbiter. The winner keeps its grant while it keeps
// requesting; a hold-limit counter forces rotation when others are waiting.
module arbiter_round_robin_hold
  import arbiter_round_robin_hold_pkg::*;
#(
  parameter int WORD_WIDTH  = 4,
  parameter int INDEX_WIDTH = clog2_width(WORD_WIDTH),
  parameter int MAX_HOLD    = 8,
  parameter int HOLD_WIDTH  = 4
) (
  input  logic                   clock,
  input  logic                   clear,
  input  logic [WORD_WIDTH-1:0]  requests,
  output logic [WORD_WIDTH-1:0]  grant,
  output logic [INDEX_WIDTH-1:0] grant_index,
  output logic                   grant_valid,
  output logic                   grant_forced
);

  // After reset the "last" winner is the top bit, so bit 0 has priority.
  localparam logic [WORD_WIDTH-1:0] LAST_GRANT_RESET = {1'b1, {(WORD_WIDTH-1){1'b0}}};
  localparam logic [HOLD_WIDTH-1:0] HOLD_LAST        = HOLD_WIDTH'(MAX_HOLD - 1);
  localparam logic [HOLD_WIDTH-1:0] HOLD_SAT         = {HOLD_WIDTH{1'b1}};

  arb_state_e             state_q, state_d;
  logic [WORD_WIDTH-1:0]  grant_q, grant_d;
  logic [WORD_WIDTH-1:0]  last_grant_q, last_grant_d;
  logic [HOLD_WIDTH-1:0]  hold_q, hold_d;
  logic [INDEX_WIDTH-1:0] index_q, index_d;
  logic                   valid_q, valid_d;
  logic                   forced_q, forced_d;

  logic [WORD_WIDTH-1:0]  pick;
  logic                   winner_active;
  logic                   others_waiting;
  logic                   limit_hit;

  arbiter_round_robin_hold_select #(
    .WORD_WIDTH (WORD_WIDTH)
  ) u_select (
    .requests   (requests),
    .last_grant (last_grant_q),
    .pick       (pick)
  );

  assign winner_active  = |(requests & grant_q);
  assign others_waiting = |(requests & ~grant_q);
  assign limit_hit      = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);

  // Next-state, next-grant and hold-counter decisions.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch to remember the old value.
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    hold_d       = hold_q;
    forced_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (requests != '0) begin
          grant_d      = pick;
          last_grant_d = pick;
          hold_d       = '0;
          state_d      = GRANTED;
        end
      end

      GRANTED: begin
        if (!winner_active) begin
          // Winner let go: hand over without a dead cycle, or fall idle.
          hold_d = '0;
          if (requests != '0) begin
            grant_d      = pick;
            last_grant_d = pick;
          end else begin
            grant_d = '0;
            state_d = IDLE;
          end
        end else if (limit_hit) begin
          // Hold budget used up: rotate only if somebody else is waiting.
          hold_d = '0;
          if (others_waiting) begin
            grant_d      = pick;
            last_grant_d = pick;
            forced_d     = 1'b1;
          end
        end else if (hold_q != HOLD_SAT) begin
          hold_d = hold_q + HOLD_WIDTH'(1);
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // One-hot to binary encoding of the next grant, registered alongside it.
  always_comb begin
    index_d = '0;
    for (int i = 0; i < WORD_WIDTH; i++) begin
      if (grant_d[i]) index_d = index_d | INDEX_WIDTH'(i);
    end
    valid_d = |grant_d;
  end

  // State and output registers; clear drops any grant at once.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= LAST_GRANT_RESET;
      hold_q       <= '0;
      index_q      <= '0;
      valid_q      <= 1'b0;
      forced_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      hold_q       <= hold_d;
      index_q      <= index_d;
      valid_q      <= valid_d;
      forced_q     <= forced_d;
    end
  end

  assign grant        = grant_q;
  assign grant_index  = index_q;
  assign grant_valid  = valid_q;
  assign grant_forced = forced_q;

endmodule
